// File: rtl/fifo_pkg.sv
// Shared types and constants for the synchronous FIFO read side.
package fifo_pkg;

    // Occupancy of the two-entry first-word-fall-through output buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    // Number of words that may sit between storage and the consumer.
    localparam int OUT_BUF_DEPTH = 2;

endpackage

// File: rtl/read_pointer.sv
// Read pointer: ADDR_WIDTH+1-bit wrapping counter with increment enable.
// The extra top bit is the wrap bit that keeps full and empty distinct.
module read_pointer #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                inc,
    output logic [ADDR_WIDTH:0] ptr
);

    // Advance modulo 2^(ADDR_WIDTH+1) whenever a memory read is issued.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/read_interface.sv
// Read side of the synchronous FIFO. Owns the read pointer, detects empty
// storage against the write pointer, issues reads to the 1-cycle-latency
// memory and presents words through a first-word-fall-through valid/ready
// port backed by a 2-entry output buffer.
// Optional feature macro: FIFO_RD_LEVEL_EN adds the read_level output.
module read_interface
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH:0]   write_addr,
    output logic [ADDR_WIDTH:0]   read_addr,
    output logic                  mem_read_en,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    input  logic                  read_ready,
`ifdef FIFO_RD_LEVEL_EN
    output logic [ADDR_WIDTH:0]   read_level,
`endif
    output logic                  empty
);

    localparam int PW = ADDR_WIDTH + 1;

    buf_state_t            state;
    buf_state_t            state_next;
    logic [1:0]            count;
    logic                  inflight;
    logic                  push;
    logic                  pop;
    logic                  mem_empty;
    logic [2:0]            occupancy;
    logic [DATA_WIDTH-1:0] slot0;
    logic [DATA_WIDTH-1:0] slot1;

    read_pointer #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_pointer (
        .clk  (clk),
        .rstn (rstn),
        .inc  (mem_read_en),
        .ptr  (read_addr)
    );

    // Issue logic: read storage only while the buffer can absorb the word.
    always_comb begin
        mem_empty   = (read_addr == write_addr);
        pop         = read_valid && read_ready;
        push        = inflight;
        occupancy   = {1'b0, count} + {2'b00, inflight};
        // Words already committed (buffered or in flight) minus the one
        // leaving this cycle must leave room for one more.
        mem_read_en = rstn && !mem_empty &&
                      (occupancy < (3'(OUT_BUF_DEPTH) + {2'b00, pop}));
    end

    // Memory data arrives one cycle after the strobe; track it as a push.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight <= 1'b0;
        end else begin
            inflight <= mem_read_en;
        end
    end

    // Buffer FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Buffer FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (push) state_next = ONE;
            end
            ONE: begin
                if (push && !pop)      state_next = TWO;
                else if (pop && !push) state_next = EMPTY;
            end
            TWO: begin
                if (pop && !push) state_next = ONE;
            end
            default: state_next = EMPTY;
        endcase
    end

    // Buffer FSM outputs: head presence and word count.
    always_comb begin
        read_valid = (state != EMPTY);
        empty      = (state == EMPTY);
        case (state)
            ONE:     count = 2'd1;
            TWO:     count = 2'd2;
            default: count = 2'd0;
        endcase
    end

    // Buffer slots: slot0 is the head and only moves on a pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) slot0 <= mem_read_data;
                end
                ONE: begin
                    if (push && pop) slot0 <= mem_read_data;
                    else if (push)   slot1 <= mem_read_data;
                end
                TWO: begin
                    if (pop) begin
                        slot0 <= slot1;
                        if (push) slot1 <= mem_read_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign read_data = slot0;

`ifdef FIFO_RD_LEVEL_EN
    // Total words held: still in storage plus buffered plus in flight.
    always_comb begin
        read_level = (write_addr - read_addr) + PW'(count) + PW'(inflight);
    end
`endif

    // The issue rule never lets a word arrive into a full buffer.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rstn)
        !(state == TWO && push && !pop)
    );

endmodule

// File: doc/read_interface.md
# read_interface

Read side of the synchronous FIFO and the counterpart of the write interface. It owns the read pointer and compares it against the write pointer to detect empty storage. It issues reads to the 1-cycle-latency storage memory and presents words to the consumer through a first-word-fall-through valid/ready port. A 2-entry output buffer sustains one word per cycle under continuous `read_ready`.

## Interface
- `DATA_WIDTH`, 8, word width.
- `ADDR_WIDTH`, 5, memory index width; depth 2^ADDR_WIDTH; pointers carry one extra wrap bit.

- `clk`  in  1  clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `write_addr`  in  ADDR_WIDTH+1  write pointer from the write side.
- `read_addr`  out  ADDR_WIDTH+1  read pointer. Low ADDR_WIDTH bits index memory. Fed to the write side for full detection.
- `mem_read_en`  out  1  memory read strobe for `read_addr[ADDR_WIDTH-1:0]`.
- `mem_read_data`  in  DATA_WIDTH  memory output, valid the cycle after `mem_read_en`.
- `read_data`  out  DATA_WIDTH  head word.
- `read_valid`  out  1  head word present.
- `read_ready`  in  1  consumer accepts the head.
- `empty`  out  1  equals `!read_valid`.

## Operation
- Reset is asynchronous, active-low, and all state clears immediately on assertion:
  - `read_addr`=0, buffer EMPTY, in-flight flag 0.
  - `mem_read_en`=0, `read_valid`=0, `empty`=1, `read_data`=0.
- Storage empty condition: `mem_empty` = (`read_addr` == `write_addr`), full ADDR_WIDTH+1-bit compare.
- `pop` = `read_valid && read_ready`.
- `inflight` = `mem_read_en` registered one cycle; marks arrival of `mem_read_data` (push).
- Issue rule (combinational): `mem_read_en` = `!mem_empty && (count + inflight - pop) < 2`, where count ∈ {0,1,2}.
- On `mem_read_en`, `read_addr` increments modulo 2^(ADDR_WIDTH+1) at the clock edge.
- Buffer FSM (states EMPTY, ONE, TWO; slot0 is the head):
  - EMPTY: push → ONE, slot0←data.
  - ONE: push & pop → ONE, slot0←data. Push only → TWO, slot1←data. Pop only → EMPTY.
  - TWO: pop → ONE, slot0←slot1. Push & pop → TWO, slot0←slot1, slot1←data.
  - TWO with push and no pop is unreachable because of the issue rule; covered by an assertion.
- `read_valid` = state != EMPTY. `read_data` = slot0.
- The head holds stable while `read_valid && !read_ready`.
- A write and a read never target the same address in one cycle, since a read is only issued after the write pointer has advanced.

## Timing
- Write accepted in cycle N (write pointer advances at the end of N):
  - `mem_read_en` in N+1.
  - `mem_read_data` in N+2.
  - `read_valid` in N+3 when the buffer was EMPTY.
- Steady state with `read_ready`=1: one word per cycle, no bubbles.
- Back-pressure: at most 2 words leave storage beyond the consumer; `read_addr` stops advancing after that.
- Wrap-around: the pointer rolls from 2^(ADDR_WIDTH+1)-1 to 0; the wrap bit keeps full and empty distinct.
- Reset mid-operation: a word in flight is dropped and buffered words are discarded. The write side shares `rstn`, so the pointers stay consistent.

## Configuration
- `FIFO_RD_LEVEL_EN` defined:
  - Adds output `read_level` [ADDR_WIDTH:0] = (`write_addr` − `read_addr`) + count + inflight.
  - This is the total words held, range 0..2^ADDR_WIDTH, and is 0 after reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- `fifo_pkg`: `buf_state_t` enum (EMPTY, ONE, TWO) and constant `OUT_BUF_DEPTH`=2.
- Sub-module `read_pointer`: ADDR_WIDTH+1-bit counter with increment enable, mirroring the write pointer. Instantiated once.

## Test plan
- Reset: hold `rstn`=0 mid-stream → `read_addr`=0, `read_valid`=0, `mem_read_en`=0, `empty`=1, asynchronously.
- Single word: `write_addr` 0→1 at cycle N, memory returns 0xA5 → `mem_read_en` one pulse in N+1; `read_valid`=1, `read_data`=0xA5 from N+3, held until `read_ready`.
- Back-pressure: load 5 words (0x01..0x05) with `read_ready`=0 → exactly 2 `mem_read_en` pulses, `read_addr`=2, state TWO. Then `read_ready`=1 → 0x01..0x05 delivered on 5 consecutive cycles.
- Streaming: one write per cycle and `read_ready`=1 for 64 words → 64 consecutive `read_valid` cycles, data in order.
- Wrap: ADDR_WIDTH=2, stream 20 words → `read_addr` passes 7→0 twice, order intact, `empty`=1 at end. With `FIFO_RD_LEVEL_EN`, `read_level` tracks and ends at 0.
- Reset mid-operation: state TWO with a read in flight, assert `rstn`=0 → all outputs at reset values; after release, the next written word appears at latency 3.
